// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
//   CPU-side transfer controller feeding an SPI serializer. CPU words are
//   buffered in a TX FIFO. Each word is presented on spi_tx_data/spi_tx_valid
//   while slave select is driven. Each word the serializer returns is
//   latched into an RX holding register.
//
// Ports
//   clk, rst          clock (posedge); asynchronous active-low reset
//   wr_en, wr_data    CPU push into the TX FIFO (dropped while tx_full)
//   tx_full           TX FIFO full
//   rd_en             CPU pop of the RX holding register
//   rd_data           last received word
//   rx_valid          rd_data holds an unread word
//   rx_overrun        sticky: a new word arrived while rx_valid was high
//   busy              FSM active or TX FIFO not empty
//   timeout_err       sticky: serializer did not answer in time; wr_en clears
//   spi_tx_data       word to serializer (data_to_transmit)
//   spi_tx_valid      serializer data_transmit_valid
//   spi_rx_data       word from serializer (data_in)
//   spi_rx_valid      serializer data_in_valid
//   ss_n              slave select, active-low
//   irq               rx_valid | timeout_err, registered (SPI_XFER_IRQ_EN only)
//
// Configuration macro: SPI_XFER_IRQ_EN enables the registered irq output;
// when it is not defined, irq is tied low.

`ifndef W_CPU
`define W_CPU 32
`endif

module spi_xfer_ctrl #(
  parameter int unsigned W_Data    = `W_CPU,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned W_Counter = 5,
  parameter int unsigned TIMEOUT   = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [W_Data-1:0] wr_data,
  output logic              tx_full,
  input  logic              rd_en,
  output logic [W_Data-1:0] rd_data,
  output logic              rx_valid,
  output logic              rx_overrun,
  output logic              busy,
  output logic              timeout_err,
  output logic [W_Data-1:0] spi_tx_data,
  output logic              spi_tx_valid,
  input  logic [W_Data-1:0] spi_rx_data,
  input  logic              spi_rx_valid,
  output logic              ss_n,
  output logic              irq
);

  localparam int unsigned AW        = $clog2(DEPTH);
  // The counter is widened if W_Counter cannot hold TIMEOUT, so the
  // saturation point is always reachable.
  localparam int unsigned W_CNT_MIN = $clog2(TIMEOUT + 1);
  localparam int unsigned W_CNT     = (W_Counter > W_CNT_MIN) ? W_Counter : W_CNT_MIN;
  localparam logic [W_CNT-1:0] CNT_MAX  = W_CNT'(TIMEOUT);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GUARD} state_e;

  state_e            state_q, state_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic              ss_n_q, ss_n_d;
  logic              tx_valid_q, tx_valid_d;
  logic [W_Data-1:0] tx_data_q, tx_data_d;
  logic [W_Data-1:0] rd_data_q;
  logic              rx_valid_q, rx_overrun_q, timeout_err_q;
  logic              capture, timeout_set;

  logic [W_Data-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q;
  logic              push, pop, fifo_empty;

  assign tx_full    = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = wr_en && !tx_full;
  assign pop        = (state_q == LOAD);

  // TX FIFO storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Outputs are registered. spi_tx_valid is asserted only from inside SHIFT,
  // so it follows ss_n by one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ss_n_d      = ss_n_q;
    tx_valid_d  = 1'b0;
    tx_data_d   = tx_data_q;
    capture     = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        tx_data_d = mem_q[rptr_q];
        ss_n_d    = 1'b0;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (spi_rx_valid) begin
          capture = 1'b1;
          // Back-to-back only when a word is already waiting; ss_n stays low.
          state_d = fifo_empty ? GUARD : LOAD;
          ss_n_d  = fifo_empty;
        end else if (cnt_q == CNT_MAX) begin
          timeout_set = 1'b1;
          state_d     = GUARD;
          ss_n_d      = 1'b1;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      GUARD: begin
        ss_n_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ss_n_q        <= 1'b1;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      rd_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ss_n_q     <= ss_n_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      if (capture) begin
        rd_data_q  <= spi_rx_data;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !rd_en) rx_overrun_q <= 1'b1;
        else if (rd_en)           rx_overrun_q <= 1'b0;
      end else if (rd_en) begin
        rx_valid_q   <= 1'b0;
        rx_overrun_q <= 1'b0;
      end
      if (timeout_set) timeout_err_q <= 1'b1;
      else if (wr_en)  timeout_err_q <= 1'b0;
    end
  end

  assign rd_data      = rd_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_overrun_q;
  assign timeout_err  = timeout_err_q;
  assign spi_tx_data  = tx_data_q;
  assign spi_tx_valid = tx_valid_q;
  assign ss_n         = ss_n_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

`ifdef SPI_XFER_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= rx_valid_q | timeout_err_q;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
